// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate extender / narrower pair.
// Contents: EOp encodings, occupancy-state encoding for the 2-entry output buffer,
// and the payload record carried through the buffer.
package imm_ext_pkg;

  localparam int unsigned IMM_W  = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned EOP_W  = 2;

  localparam logic [EOP_W-1:0] EOP_SIGN = 2'b00;
  localparam logic [EOP_W-1:0] EOP_ZERO = 2'b01;
  localparam logic [EOP_W-1:0] EOP_LUI  = 2'b10;
  localparam logic [EOP_W-1:0] EOP_RSV  = 2'b11;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_t;

  // One narrowed result: {op, fit, imm} = 19 bits.
  typedef struct packed {
    logic [EOP_W-1:0] op;
    logic             fit;
    logic [IMM_W-1:0] imm;
  } narrow_pay_t;

  localparam int unsigned PAY_W = $bits(narrow_pay_t);

endpackage

// File: rtl/narrow_fifo2.sv
// Generic 2-entry valid/ready buffer in FIFO order; sustains one word per cycle.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake (in_ready depends only on occupancy)
//   in_data  [W]        word pushed on in_valid && in_ready
//   out_valid/out_ready downstream handshake
//   out_data [W]        head entry; holds the last popped word while empty
module narrow_fifo2
  import imm_ext_pkg::*;
#(
  parameter int unsigned W = 19
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  buf_state_t   state_q, state_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic         push, pop;

  assign push = in_valid && in_ready_q;
  assign pop  = out_valid_q && out_ready;

  // State and storage registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      head_q      <= '0;
      tail_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Occupancy transitions; head is always the oldest word.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (push) begin
          head_d  = in_data;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          head_d = in_data;
        end else if (push) begin
          tail_d  = in_data;
          state_d = ST_FULL;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = head_q;

endmodule

// File: rtl/imm_narrow.sv
// Narrows a 32-bit value to the 16-bit immediate that the extender would need
// to regenerate it under the given EOp, flags exact regeneration (fit), and
// streams results through a 2-entry buffer.
// Optional: define IMM_NARROW_STATS_EN to enable the saturating misfit counter;
// otherwise misfit_cnt is tied to 0.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   in_valid/in_ready, in_data, in_op   upstream stream
//   out_valid/out_ready, out_imm, out_fit, out_op   downstream stream
//   misfit_cnt [CNT_W]               accepted words with fit=0 (saturating)
module imm_narrow
  import imm_ext_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [EOP_W-1:0]  in_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IMM_W-1:0]  out_imm,
  output logic              out_fit,
  output logic [EOP_W-1:0]  out_op,
  output logic [CNT_W-1:0]  misfit_cnt
);

  narrow_pay_t in_pay;
  narrow_pay_t out_pay;
  logic [PAY_W-1:0] out_bits;

  // Inverse of the extender: pick the kept half, check the dropped half.
  always_comb begin
    in_pay.op  = in_op;
    in_pay.imm = in_data[15:0];
    in_pay.fit = 1'b0;
    unique case (in_op)
      EOP_SIGN: in_pay.fit = (in_data[31:16] == {16{in_data[15]}});
      EOP_ZERO: in_pay.fit = (in_data[31:16] == 16'h0000);
      EOP_LUI: begin
        in_pay.imm = in_data[31:16];
        in_pay.fit = (in_data[15:0] == 16'h0000);
      end
      EOP_RSV:  in_pay.fit = 1'b0;
      default:  in_pay.fit = 1'b0;
    endcase
  end

  narrow_fifo2 #(.W(PAY_W)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pay),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_bits)
  );

  assign out_pay = narrow_pay_t'(out_bits);
  assign out_imm = out_pay.imm;
  assign out_fit = out_pay.fit;
  assign out_op  = out_pay.op;

`ifdef IMM_NARROW_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push;

  assign push = in_valid && in_ready;

  // Saturating count of accepted words that cannot be regenerated exactly.
  always_comb begin
    cnt_d = cnt_q;
    if (push && !in_pay.fit && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign misfit_cnt = cnt_q;
`else
  assign misfit_cnt = '0;
`endif

endmodule

// File: tb/tb_imm_narrow.sv
module tb_imm_narrow;

  localparam int unsigned CNT_W = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_data;
  logic [1:0]        in_op;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_imm;
  logic              out_fit;
  logic [1:0]        out_op;
  logic [CNT_W-1:0]  misfit_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  imm_narrow #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_imm    (out_imm),
    .out_fit    (out_fit),
    .out_op     (out_op),
    .misfit_cnt (misfit_cnt)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  op;
    logic [15:0] imm;
    logic        fit;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one edge; inputs are changed and outputs sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bench-side counter model for an accepted word.
  task automatic note_push(input logic fit);
`ifdef IMM_NARROW_STATS_EN
    if (!fit && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
`else
    if (!fit) exp_cnt = 0;
`endif
  endtask

  initial begin
    vecs[0] = '{32'hFFFF8000, 2'b00, 16'h8000, 1'b1};
    vecs[1] = '{32'h00018000, 2'b00, 16'h8000, 1'b0};
    vecs[2] = '{32'h0000ABCD, 2'b01, 16'hABCD, 1'b1};
    vecs[3] = '{32'h12340000, 2'b10, 16'h1234, 1'b1};
    vecs[4] = '{32'h12340001, 2'b10, 16'h1234, 1'b0};
    vecs[5] = '{32'h00007FFF, 2'b00, 16'h7FFF, 1'b1};
    vecs[6] = '{32'hFFFF7FFF, 2'b00, 16'h7FFF, 1'b0};
    vecs[7] = '{32'hFFFFABCD, 2'b01, 16'hABCD, 1'b0};
    vecs[8] = '{32'h00000000, 2'b11, 16'h0000, 1'b0};
    vecs[9] = '{32'hDEADBEEF, 2'b11, 16'hBEEF, 1'b0};

    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_op = '0; out_ready = 1'b0;
    step(); step();
    reset = 1'b0;

    // Reset then idle.
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_out_valid", 32'(out_valid), 32'd0);
      chk("idle_in_ready", 32'(in_ready), 32'd1);
      chk("idle_misfit", 32'(misfit_cnt), 32'd0);
    end
    chk("rst_out_imm", 32'(out_imm), 32'd0);
    chk("rst_out_fit", 32'(out_fit), 32'd0);
    chk("rst_out_op", 32'(out_op), 32'd0);

    // Table: one word at a time, visible one cycle after the push.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = vecs[i].data; in_op = vecs[i].op;
      step();
      note_push(vecs[i].fit);
      in_valid = 1'b0;
      chk("vec_out_valid", 32'(out_valid), 32'd1);
      chk("vec_out_imm", 32'(out_imm), 32'(vecs[i].imm));
      chk("vec_out_fit", 32'(out_fit), 32'(vecs[i].fit));
      chk("vec_out_op", 32'(out_op), 32'(vecs[i].op));
      chk("vec_misfit", 32'(misfit_cnt), 32'(exp_cnt));
      step();
      chk("vec_drained", 32'(out_valid), 32'd0);
    end

    // Backpressure: three back-to-back words, only two accepted.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h00000001; in_op = 2'b01;
    step();
    chk("bp_ready_after1", 32'(in_ready), 32'd1);
    chk("bp_head1", 32'(out_imm), 32'h0001);
    in_data = 32'h00000002;
    step();
    chk("bp_ready_after2", 32'(in_ready), 32'd0);
    in_data = 32'h00000003;
    step();
    chk("bp_ready_held", 32'(in_ready), 32'd0);
    chk("bp_head_held", 32'(out_imm), 32'h0001);
    in_data = 32'h0000FFFF;
    step();
    chk("bp_head_ignored", 32'(out_imm), 32'h0001);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_pop1_valid", 32'(out_valid), 32'd1);
    chk("bp_pop1_imm", 32'(out_imm), 32'h0002);
    chk("bp_pop1_ready", 32'(in_ready), 32'd1);
    step();
    chk("bp_pop2_valid", 32'(out_valid), 32'd0);
    chk("bp_pop2_ready", 32'(in_ready), 32'd1);

    // Streaming: one word per cycle, in order, never full.
    in_valid = 1'b1; in_op = 2'b01;
    for (int i = 0; i < 10; i++) begin
      in_data = 32'(i * 3 + 16);
      step();
      chk("st_valid", 32'(out_valid), 32'd1);
      chk("st_imm", 32'(out_imm), 32'(i * 3 + 16));
      chk("st_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("st_drained", 32'(out_valid), 32'd0);

    // Reserved op words never fit; counter saturates when enabled.
    in_valid = 1'b1; in_op = 2'b11;
    for (int i = 0; i < 5; i++) begin
      in_data = 32'(i);
      step();
      note_push(1'b0);
      chk("rsv_fit", 32'(out_fit), 32'd0);
    end
    in_valid = 1'b0;
    chk("rsv_misfit", 32'(misfit_cnt), 32'(exp_cnt));
    step();

    // Reset with two words buffered discards them.
    out_ready = 1'b0; in_valid = 1'b1; in_op = 2'b00;
    in_data = 32'h00000011; step();
    in_data = 32'h00000022; step();
    in_valid = 1'b0;
    chk("mr_full", 32'(in_ready), 32'd0);
    reset = 1'b1;
    step();
    exp_cnt = 0;
    chk("mr_out_valid", 32'(out_valid), 32'd0);
    chk("mr_in_ready", 32'(in_ready), 32'd1);
    chk("mr_misfit", 32'(misfit_cnt), 32'(exp_cnt));
    reset = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mr_quiet", 32'(out_valid), 32'd0);
    end
    in_valid = 1'b1; in_data = 32'hFFFFFFFF; in_op = 2'b00;
    step();
    in_valid = 1'b0;
    chk("mr_new_valid", 32'(out_valid), 32'd1);
    chk("mr_new_imm", 32'(out_imm), 32'hFFFF);
    chk("mr_new_fit", 32'(out_fit), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
